fetch_unit: RTL and testbench

Instruction-fetch (IF) stage of the 32-bit RISC-V pipeline. It owns the program counter and drives the word-aligned byte address into the synchronous instruction memory, which has 1-cycle read latency. It pairs each returned word with its PC and presents an instruction/PC bundle to the decode stage with a valid/stall handshake. It also handles stalls and branch/jump redirects, and flags fetches beyond the end of instruction memory.

---
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and
// presents an instruction/PC bundle to decode with a valid/stall handshake and redirect flush.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        if_valid_o,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_pc_plus4_o,
   output logic        if_fault_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc_q;
   logic [31:0] resp_pc_q;
   logic [31:0] hold_instr_q;
   logic        resp_valid_q;
   logic        hold_valid_q;
   logic        issue;
   logic        beyond_imem;
   logic        unused_redirect_lsb;

   // A fresh fetch goes out unless the word arriving now must be parked (stall on response)
   // or the parked word is still waiting for decode.
   assign issue = (!hold_valid_q && !(resp_valid_q && stall_i)) ||
                  (hold_valid_q && !stall_i);

   assign unused_redirect_lsb = ^redirect_pc_i[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= {RESET_PC[31:2], 2'b00};
         resp_pc_q    <= {RESET_PC[31:2], 2'b00};
         resp_valid_q <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_instr_q <= NOP;
      end else if (redirect_i) begin
         pc_q         <= {redirect_pc_i[31:2], 2'b00};
         resp_valid_q <= 1'b0;
         hold_valid_q <= 1'b0;
      end else if (issue) begin
         resp_valid_q <= 1'b1;
         resp_pc_q    <= pc_q;
         pc_q         <= pc_q + 32'd4;
         hold_valid_q <= 1'b0;
      end else if (resp_valid_q) begin
         // Memory output is only good for one cycle; capture it before it is lost.
         hold_instr_q <= imem_rdata;
         hold_valid_q <= 1'b1;
         resp_valid_q <= 1'b0;
      end
   end

   assign imem_addr     = pc_q;
   assign if_valid_o    = resp_valid_q || hold_valid_q;
   assign if_pc_o       = resp_pc_q;
   assign if_pc_plus4_o = resp_pc_q + 32'd4;
   assign beyond_imem   = {2'b00, resp_pc_q[31:2]} >= IMEM_WORDS;

   always_comb begin
      if_fault_o = if_valid_o && beyond_imem;
      if_instr_o = NOP;
      if (hold_valid_q)
         if_instr_o = hold_instr_q;
      else if (resp_valid_q)
         if_instr_o = imem_rdata;
      if (if_fault_o)
         if_instr_o = NOP;
   end

   a_resp_hold_exclusive : assert property (
      @(posedge clk) disable iff (!rst_n) !(resp_valid_q && hold_valid_q));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for sequential/redirect/fault behaviour,
// plus hand-written sequences for stall release, redirect during stall and mid-stall reset.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] I0  = 32'h1000_0000;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        if_valid_o;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_pc_plus4_o;
   logic        if_fault_o;

   int errors = 0;
   int checks = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(256)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
      .if_pc_plus4_o(if_pc_plus4_o), .if_fault_o(if_fault_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: 256 words, imem[i] = 0x1000_0000 + i, poison beyond the end.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [29:0] idx;
      idx = a[31:2];
      if (idx < 30'd256) return I0 + {2'b00, idx};
      return 32'hDEAD_BEEF;
   endfunction

   always @(posedge clk) imem_rdata <= mem_word(imem_addr);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_bundle(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] instr, input logic f, input logic [31:0] addr);
      chk({tag, " valid"}, {31'd0, if_valid_o}, {31'd0, v});
      chk({tag, " pc"}, if_pc_o, pc);
      chk({tag, " pc+4"}, if_pc_plus4_o, pc + 32'd4);
      chk({tag, " instr"}, if_instr_o, instr);
      chk({tag, " fault"}, {31'd0, if_fault_o}, {31'd0, f});
      chk({tag, " addr"}, imem_addr, addr);
   endtask

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
      logic [31:0] addr;
   } vec_t;

   vec_t vecs[21];

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit found;
      // cycle inputs, then outputs expected during that same cycle
      vecs[0]  = '{0, 0, 32'h0,         0, 32'h0,         NOP,     0, 32'h0};
      vecs[1]  = '{0, 0, 32'h0,         1, 32'h0,         I0 + 0,  0, 32'h4};
      vecs[2]  = '{0, 0, 32'h0,         1, 32'h4,         I0 + 1,  0, 32'h8};
      vecs[3]  = '{0, 0, 32'h0,         1, 32'h8,         I0 + 2,  0, 32'hC};
      vecs[4]  = '{0, 0, 32'h0,         1, 32'hC,         I0 + 3,  0, 32'h10};
      vecs[5]  = '{0, 1, 32'h43,        1, 32'h10,        I0 + 4,  0, 32'h14};
      vecs[6]  = '{0, 0, 32'h0,         0, 32'h10,        NOP,     0, 32'h40};
      vecs[7]  = '{0, 0, 32'h0,         1, 32'h40,        I0 + 16, 0, 32'h44};
      vecs[8]  = '{0, 1, 32'h3FC,       1, 32'h44,        I0 + 17, 0, 32'h48};
      vecs[9]  = '{0, 0, 32'h0,         0, 32'h44,        NOP,     0, 32'h3FC};
      vecs[10] = '{0, 0, 32'h0,         1, 32'h3FC,       I0 + 255,0, 32'h400};
      vecs[11] = '{0, 0, 32'h0,         1, 32'h400,       NOP,     1, 32'h404};
      vecs[12] = '{0, 1, 32'hFFFF_FFFF, 1, 32'h404,       NOP,     1, 32'h408};
      vecs[13] = '{0, 0, 32'h0,         0, 32'h404,       NOP,     0, 32'hFFFF_FFFC};
      vecs[14] = '{0, 0, 32'h0,         1, 32'hFFFF_FFFC, NOP,     1, 32'h0};
      vecs[15] = '{0, 0, 32'h0,         1, 32'h0,         I0 + 0,  0, 32'h4};
      vecs[16] = '{0, 0, 32'h0,         1, 32'h4,         I0 + 1,  0, 32'h8};
      vecs[17] = '{1, 0, 32'h0,         1, 32'h8,         I0 + 2,  0, 32'hC};
      vecs[18] = '{1, 0, 32'h0,         1, 32'h8,         I0 + 2,  0, 32'hC};
      vecs[19] = '{1, 0, 32'h0,         1, 32'h8,         I0 + 2,  0, 32'hC};
      vecs[20] = '{0, 0, 32'h0,         1, 32'h8,         I0 + 2,  0, 32'hC};

      rst_n = 1'b0;
      stall_i = 1'b0;
      redirect_i = 1'b0;
      redirect_pc_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_bundle("reset", 1'b0, 32'h0, NOP, 1'b0, 32'h0);
      next_cycle();
      rst_n = 1'b1;

      for (int unsigned i = 0; i < 21; i++) begin
         stall_i       = vecs[i].stall;
         redirect_i    = vecs[i].redir;
         redirect_pc_i = vecs[i].rpc;
         @(negedge clk);
         chk_bundle($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc, vecs[i].instr,
                    vecs[i].fault, vecs[i].addr);
         next_cycle();
      end

      // After the stall release the next consumed bundle must be PC 12: nothing lost or repeated.
      found = 1'b0;
      for (int n = 0; n < 4 && !found; n++) begin
         @(negedge clk);
         if (if_valid_o) found = 1'b1;
         else next_cycle();
      end
      chk("post-release found", {31'd0, found}, 32'd1);
      chk("post-release pc", if_pc_o, 32'hC);
      chk("post-release instr", if_instr_o, I0 + 3);
      next_cycle();

      // Fill the hold, then redirect while still stalled.
      stall_i = 1'b1;
      @(negedge clk);
      chk_bundle("rs-A", 1'b1, 32'h10, I0 + 4, 1'b0, 32'h14);
      next_cycle();
      redirect_i = 1'b1;
      redirect_pc_i = 32'h43;
      @(negedge clk);
      chk_bundle("rs-B", 1'b1, 32'h10, I0 + 4, 1'b0, 32'h14);
      next_cycle();
      redirect_i = 1'b0;
      @(negedge clk);
      chk_bundle("rs-C", 1'b0, 32'h10, NOP, 1'b0, 32'h40);
      next_cycle();
      stall_i = 1'b0;
      @(negedge clk);
      chk_bundle("rs-D", 1'b1, 32'h40, I0 + 16, 1'b0, 32'h44);
      next_cycle();

      // Reset while the hold register is full.
      stall_i = 1'b1;
      @(negedge clk);
      chk_bundle("rh-E", 1'b1, 32'h44, I0 + 17, 1'b0, 32'h48);
      next_cycle();
      @(negedge clk);
      chk_bundle("rh-F", 1'b1, 32'h44, I0 + 17, 1'b0, 32'h48);
      #1;
      rst_n = 1'b0;
      stall_i = 1'b0;
      #1;
      chk_bundle("rh-rst", 1'b0, 32'h0, NOP, 1'b0, 32'h0);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      chk_bundle("rr-0", 1'b0, 32'h0, NOP, 1'b0, 32'h0);
      next_cycle();
      @(negedge clk);
      chk_bundle("rr-1", 1'b1, 32'h0, I0 + 0, 1'b0, 32'h4);
      next_cycle();
      @(negedge clk);
      chk_bundle("rr-2", 1'b1, 32'h4, I0 + 1, 1'b0, 32'h8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
